// File: rtl/mem_port_arbiter.sv
// Arbitrates a CPU fetch port and data port onto one fixed-latency unified memory.
// Optional ARB_PERF_EN adds saturating grant and stall-cycle counters.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ready,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [63:0]       d_wdata,
   output logic [63:0]       d_rdata,
   output logic              d_ready,
   output logic              stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   input  logic [63:0]       mem_rdata
`ifdef ARB_PERF_EN
   ,
   output logic [31:0]       perf_if_grants,
   output logic [31:0]       perf_d_grants,
   output logic [31:0]       perf_stall_cycles
`endif
);

   localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(MEM_LAT - 1);
   localparam logic [ST_W-1:0]  STARVE_LIM = ST_W'(STARVE_MAX);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [ST_W-1:0]   starve_q;
   logic              port_d_q;   // owner of the in-flight transaction: 1 = data port
   logic              we_q;
   logic              sel_hi_q;
   logic [ADDR_W-1:0] addr_q;
   logic [63:0]       wdata_q;
   logic [31:0]       if_rdata_q;
   logic [63:0]       d_rdata_q;

   logic d_req;
   logic grant_if;
   logic grant_d;
   logic last_wait;
   logic unused_addr_bits;

   assign unused_addr_bits = ^{if_addr[1:0], d_addr[2:0]};

   always_comb begin
      d_req    = d_rd | d_wr;
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (state_q == StIdle) begin
         // Data has priority until fetch has been passed over STARVE_MAX times.
         if (d_req && !(if_req && (starve_q == STARVE_LIM))) begin
            grant_d = 1'b1;
         end else if (if_req) begin
            grant_if = 1'b1;
         end
      end
   end

   assign last_wait = (state_q == StWait) && (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (grant_if || grant_d) state_d = StIssue;
         StIssue: state_d = StWait;
         StWait:  if (cnt_q == '0) state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         starve_q   <= '0;
         port_d_q   <= 1'b0;
         we_q       <= 1'b0;
         sel_hi_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (grant_if) begin
            port_d_q <= 1'b0;
            we_q     <= 1'b0;
            sel_hi_q <= if_addr[2];
            addr_q   <= {if_addr[ADDR_W-1:3], 3'b000};
         end
         if (grant_d) begin
            port_d_q <= 1'b1;
            we_q     <= d_wr;
            addr_q   <= {d_addr[ADDR_W-1:3], 3'b000};
            wdata_q  <= d_wdata;
         end
         if (grant_d && if_req) begin
            if (starve_q != STARVE_LIM) starve_q <= starve_q + ST_W'(1);
         end else if (grant_if || grant_d) begin
            starve_q <= '0;
         end
         if (state_q == StIssue) begin
            cnt_q <= CNT_INIT;
         end else if ((state_q == StWait) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (last_wait && !we_q) begin
            if (port_d_q) begin
               d_rdata_q <= mem_rdata;
            end else begin
               if_rdata_q <= sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
            end
         end
      end
   end

   assign mem_en    = (state_q == StIssue);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_ready  = (state_q == StResp) & ~port_d_q;
   assign d_ready   = (state_q == StResp) & port_d_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign stall     = (if_req & ~if_ready) | (d_req & ~d_ready);

`ifdef ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_if_grants    <= '0;
         perf_d_grants     <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (grant_if && (perf_if_grants != '1)) perf_if_grants <= perf_if_grants + 32'd1;
         if (grant_d && (perf_d_grants != '1)) perf_d_grants <= perf_d_grants + 32'd1;
         if (stall && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance with a memory model
// and a MEM_LAT=1 instance with an address-derived read pattern.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   int          errors;
   int          checks;

   logic        if_req, d_rd, d_wr, if_ready, d_ready, stall, mem_en, mem_we;
   logic [63:0] if_addr, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] if_rdata;

   logic        if_req_1, d_rd_1, d_wr_1, if_ready_1, d_ready_1, stall_1, mem_en_1, mem_we_1;
   logic [63:0] if_addr_1, d_addr_1, d_wdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
   logic [31:0] if_rdata_1;

`ifdef ARB_PERF_EN
   logic [31:0] perf_if_grants, perf_d_grants, perf_stall_cycles;
   logic [31:0] perf_if_grants_1, perf_d_grants_1, perf_stall_cycles_1;
   int          stall_seen;
`endif

   mem_port_arbiter #(.ADDR_W(64), .MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ready(if_ready), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready), .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
      , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
      .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   mem_port_arbiter #(.ADDR_W(64), .MEM_LAT(1), .STARVE_MAX(4)) dut_lat1 (
      .clk(clk), .rst_n(rst_n), .if_req(if_req_1), .if_addr(if_addr_1),
      .if_rdata(if_rdata_1), .if_ready(if_ready_1), .d_rd(d_rd_1), .d_wr(d_wr_1),
      .d_addr(d_addr_1), .d_wdata(d_wdata_1), .d_rdata(d_rdata_1), .d_ready(d_ready_1),
      .stall(stall_1), .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
      .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
`ifdef ARB_PERF_EN
      , .perf_if_grants(perf_if_grants_1), .perf_d_grants(perf_d_grants_1),
      .perf_stall_cycles(perf_stall_cycles_1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-stage read pipe gives data exactly 2 cycles after the mem_en cycle; X otherwise.
   logic [63:0] mem [0:63];
   logic [63:0] rd_s1, rd_s2, rd_lat1;
   always @(posedge clk) begin
      if (!rst_n) mem[32] <= 64'hDEADBEEF_12345678;
      else if (mem_en && mem_we) mem[mem_addr[8:3]] <= mem_wdata;
      rd_s1 <= (mem_en && !mem_we) ? mem[mem_addr[8:3]] : 64'hx;
      rd_s2 <= rd_s1;
      rd_lat1 <= mem_en_1 ? {mem_addr_1[31:0] ^ 32'hFFFF0000, mem_addr_1[31:0]} : 64'hx;
   end
   assign mem_rdata   = rd_s2;
   assign mem_rdata_1 = rd_lat1;

`ifdef ARB_PERF_EN
   always @(posedge clk) if (rst_n && stall) stall_seen <= stall_seen + 1;
`endif

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({if_ready, d_ready, mem_en, mem_we} !== 4'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b want 0000", {if_ready, d_ready, mem_en, mem_we});
      end
      checks++;
      if ({mem_addr, mem_wdata} !== 128'h0) begin
         errors++; $display("FAIL reset_mem_bus: got %h %h want 0", mem_addr, mem_wdata);
      end
      checks++;
      if ({if_rdata, d_rdata} !== 96'h0) begin
         errors++; $display("FAIL reset_rdata: got %h %h want 0", if_rdata, d_rdata);
      end
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0) begin errors++; $display("FAIL idle_no_req: mem_en=%b want 0", mem_en); end
   endtask

   task automatic test_fetch();
      @(negedge clk);
      if_req = 1'b1; if_addr = 64'h104;
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_t0: got %b want 1", stall); end
      @(negedge clk);
      checks++;
      if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 64'h100) begin
         errors++;
         $display("FAIL fetch_issue: en/we=%b addr=%h want 10 100", {mem_en, mem_we}, mem_addr);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (if_ready !== 1'b0 || stall !== 1'b1) begin
         errors++; $display("FAIL fetch_t3: ready=%b stall=%b want 0 1", if_ready, stall);
      end
      @(negedge clk);
      checks++;
      if (if_ready !== 1'b1 || d_ready !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL fetch_ready_t4: if=%b d=%b stall=%b want 1 0 0", if_ready, d_ready, stall);
      end
      checks++;
      if (if_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL fetch_rdata: got %h want deadbeef", if_rdata);
      end
      if_req = 1'b0;
      @(negedge clk);
      checks++;
      if (if_ready !== 1'b0 || mem_en !== 1'b0) begin
         errors++; $display("FAIL fetch_pulse: ready=%b en=%b want 0 0", if_ready, mem_en);
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      d_wr = 1'b1; d_addr = 64'h40; d_wdata = 64'hA5A5_0000_0000_5A5A;
      @(negedge clk);
      checks++;
      if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 64'h40
          || mem_wdata !== 64'hA5A5_0000_0000_5A5A) begin
         errors++;
         $display("FAIL wr_issue: en/we=%b addr=%h wdata=%h", {mem_en, mem_we}, mem_addr, mem_wdata);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (d_ready !== 1'b1 || if_ready !== 1'b0 || d_rdata !== 64'h0) begin
         errors++;
         $display("FAIL wr_done: d=%b if=%b rdata=%h want 1 0 0", d_ready, if_ready, d_rdata);
      end
      d_wr = 1'b0;
      @(negedge clk);
      d_rd = 1'b1; d_addr = 64'h45;
      @(negedge clk);
      checks++;
      if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 64'h40) begin
         errors++; $display("FAIL rd_issue: en/we=%b addr=%h want 10 40", {mem_en, mem_we}, mem_addr);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (d_ready !== 1'b1 || d_rdata !== 64'hA5A5_0000_0000_5A5A) begin
         errors++; $display("FAIL rd_done: d=%b rdata=%h want 1 a5a500000005a5a", d_ready, d_rdata);
      end
      d_rd = 1'b0;
      @(negedge clk);
      // Both strobes high behaves as a write to 0x48.
      d_rd = 1'b1; d_wr = 1'b1; d_addr = 64'h48; d_wdata = 64'h1122_3344_5566_7788;
      @(negedge clk);
      checks++;
      if ({mem_en, mem_we} !== 2'b11) begin
         errors++; $display("FAIL rdwr_is_write: en/we=%b want 11", {mem_en, mem_we});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (d_ready !== 1'b1 || d_rdata !== 64'hA5A5_0000_0000_5A5A) begin
         errors++; $display("FAIL rdwr_done: d=%b rdata=%h want 1 held", d_ready, d_rdata);
      end
      d_rd = 1'b0; d_wr = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [10:1] en_seen, rdy_seen;
      @(negedge clk);
      if_req = 1'b1; if_addr = 64'h100;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         en_seen[c]  = mem_en;
         rdy_seen[c] = if_ready;
         if (c == 9) if_req = 1'b0;
      end
      checks++;
      if (en_seen !== 10'b00_0010_0001) begin
         errors++; $display("FAIL b2b_issue: got %b want 0000100001", en_seen);
      end
      checks++;
      if (rdy_seen !== 10'b01_0000_1000) begin
         errors++; $display("FAIL b2b_ready: got %b want 0100001000", rdy_seen);
      end
      checks++;
      if (if_rdata !== 32'h12345678) begin
         errors++; $display("FAIL b2b_rdata_lo: got %h want 12345678", if_rdata);
      end
   endtask

   task automatic test_starve();
      logic [9:0] exp_a;
      logic [7:0] exp_b;
      logic [8:0] req_b;
      logic       got, seen_rdy;
      exp_a = 10'b10_0001_0000;
      exp_b = 8'b1000_0000;
      req_b = 9'b0_1111_1011;
      if_addr = 64'h100; d_addr = 64'h40;
      @(negedge clk);
      if_req = 1'b1; d_rd = 1'b1;
      for (int g = 0; g < 10; g++) begin
         got = 1'b0;
         for (int n = 0; n < 12 && !got; n++) begin
            @(negedge clk);
            got = mem_en;
         end
         checks++;
         if (!got) begin
            errors++; $display("FAIL starve_a_timeout: grant %0d not seen", g);
         end else if ((mem_addr == 64'h100) !== exp_a[g]) begin
            errors++;
            $display("FAIL starve_a_order: grant %0d fetch=%b want %b", g, mem_addr == 64'h100,
                     exp_a[g]);
         end
      end
      if_req = 1'b0; d_rd = 1'b0;
      repeat (4) @(negedge clk);
      if_req = req_b[0]; d_rd = 1'b1;
      for (int g = 0; g < 8; g++) begin
         got = 1'b0;
         for (int n = 0; n < 12 && !got; n++) begin
            @(negedge clk);
            got = mem_en;
         end
         if_req = req_b[g+1];
         if (g == 7) d_rd = 1'b0;
         checks++;
         if (!got) begin
            errors++; $display("FAIL starve_b_timeout: grant %0d not seen", g);
         end else if ((mem_addr == 64'h100) !== exp_b[g]) begin
            errors++;
            $display("FAIL starve_b_order: grant %0d fetch=%b want %b", g, mem_addr == 64'h100,
                     exp_b[g]);
         end
      end
      // Fetch request was withdrawn during its ISSUE; it must still complete.
      seen_rdy = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (if_ready) seen_rdy = 1'b1;
      end
      checks++;
      if (seen_rdy !== 1'b1) begin
         errors++; $display("FAIL withdrawn_completes: if_ready seen=%b want 1", seen_rdy);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      d_rd = 1'b1; d_addr = 64'h40;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_en, if_ready, d_ready} !== 3'b000 || d_rdata !== 64'h0) begin
         errors++;
         $display("FAIL rst_mid_async: en/ir/dr=%b d_rdata=%h want 000 0",
                  {mem_en, if_ready, d_ready}, d_rdata);
      end
      d_rd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({mem_en, if_ready, d_ready} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_idle: en/ir/dr=%b want 000", {mem_en, if_ready, d_ready});
         end
      end
      if_req = 1'b1; if_addr = 64'h100;
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_mid_reissue: en=%b want 1", mem_en); end
      repeat (3) @(negedge clk);
      checks++;
      if (if_ready !== 1'b1 || if_rdata !== 32'h12345678) begin
         errors++; $display("FAIL rst_mid_fetch: ready=%b rdata=%h want 1 12345678", if_ready, if_rdata);
      end
      if_req = 1'b0;
   endtask

   task automatic test_mem_lat1();
      logic [3:0] st, rdy;
      @(negedge clk);
      if_req_1 = 1'b1; if_addr_1 = 64'h20C;
      #1 st[0] = stall_1; rdy[0] = if_ready_1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         #1 st[c] = stall_1; rdy[c] = if_ready_1;
         if (c == 1) begin
            checks++;
            if (mem_en_1 !== 1'b1 || mem_addr_1 !== 64'h208) begin
               errors++; $display("FAIL lat1_issue: en=%b addr=%h want 1 208", mem_en_1, mem_addr_1);
            end
         end
      end
      checks++;
      if (st !== 4'b0111) begin errors++; $display("FAIL lat1_stall: got %b want 0111", st); end
      checks++;
      if (rdy !== 4'b1000) begin errors++; $display("FAIL lat1_ready: got %b want 1000", rdy); end
      checks++;
      if (if_rdata_1 !== 32'hFFFF0208) begin
         errors++; $display("FAIL lat1_rdata_hi: got %h want ffff0208", if_rdata_1);
      end
      if_req_1 = 1'b0;
      @(negedge clk);
   endtask

`ifdef ARB_PERF_EN
   task automatic test_perf();
      logic [4:0] is_fetch;
      is_fetch = 5'b00111;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      stall_seen = 0;
      checks++;
      if ({perf_if_grants, perf_d_grants, perf_stall_cycles} !== 96'h0) begin
         errors++; $display("FAIL perf_reset: got %h %h %h want 0", perf_if_grants, perf_d_grants,
                            perf_stall_cycles);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (is_fetch[k]) begin if_req = 1'b1; if_addr = 64'h100; end
         else begin d_rd = 1'b1; d_addr = 64'h100; end
         repeat (4) @(negedge clk);
         if_req = 1'b0; d_rd = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (perf_if_grants !== 32'd3 || perf_d_grants !== 32'd2) begin
         errors++; $display("FAIL perf_grants: got %0d %0d want 3 2", perf_if_grants, perf_d_grants);
      end
      checks++;
      if (perf_stall_cycles !== 32'd20 || stall_seen != 20) begin
         errors++;
         $display("FAIL perf_stall: got %0d (seen %0d) want 20", perf_stall_cycles, stall_seen);
      end
   endtask
`endif

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0;
      if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; if_addr = '0; d_addr = '0; d_wdata = '0;
      if_req_1 = 1'b0; d_rd_1 = 1'b0; d_wr_1 = 1'b0;
      if_addr_1 = '0; d_addr_1 = '0; d_wdata_1 = '0;
`ifdef ARB_PERF_EN
      stall_seen = 0;
`endif
      test_reset();
      test_fetch();
      test_write_read();
      test_back_to_back();
      test_starve();
      test_mem_lat1();
      test_reset_mid();
`ifdef ARB_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
